// File: rtl/calc_driver.sv
// Request-driven initiator for the calculator's switch interface: serialises
// A / operator / B as debouncer-friendly pulses, then returns the LED value.
module calc_driver #(
  parameter int PULSE_LEN  = 16,
  parameter int GAP_LEN    = 16,
  parameter int SETTLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [7:0] reqOpA,
  input  logic [2:0] reqOp,
  input  logic [7:0] reqOpB,
  output logic [7:0] dataOut,
  output logic       validOut,
  input  logic [7:0] ledIn,
  output logic       respValid,
  output logic [7:0] respData,
  output logic       respErr
);

  localparam int MAXPG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int MAXLEN = (MAXPG > SETTLE_LEN) ? MAXPG : SETTLE_LEN;
  localparam int CW     = $clog2(MAXLEN + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, RESP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    step, step_n, nsteps, nsteps_n, step_inc;
  logic [7:0]    opa, opa_n, opb, opb_n, nxt_val;
  logic [2:0]    op, op_n;
  logic          reqReady_n, validOut_n, respValid_n, respErr_n;
  logic [7:0]    dataOut_n, respData_n;

  // Value presented on dataOut for the step that follows the current one.
  always_comb begin
    step_inc = step + 2'd1;
    case (step_inc)
      2'd0:    nxt_val = opa;
      2'd1:    nxt_val = {5'b0, op};
      default: nxt_val = opb;
    endcase
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    step_n      = step;
    nsteps_n    = nsteps;
    opa_n       = opa;
    opb_n       = opb;
    op_n        = op;
    reqReady_n  = reqReady;
    dataOut_n   = dataOut;
    validOut_n  = validOut;
    respValid_n = 1'b0;
    respData_n  = respData;
    respErr_n   = respErr;
    case (state)
      IDLE: begin
        if (reqValid && reqReady) begin
          opa_n      = reqOpA;
          op_n       = reqOp;
          opb_n      = reqOpB;
          reqReady_n = 1'b0;
          if (reqOp > 3'd5) begin
            state_n     = RESP;
            respValid_n = 1'b1;
            respErr_n   = 1'b1;
            respData_n  = '0;
          end else begin
            state_n   = SETUP;
            nsteps_n  = (reqOp <= 3'd2) ? 2'd3 : 2'd2;
            step_n    = '0;
            cnt_n     = '0;
            dataOut_n = reqOpA;
            respErr_n = 1'b0;
          end
        end
      end
      SETUP: begin
        if (cnt == CW'(GAP_LEN - 1)) begin
          cnt_n      = '0;
          validOut_n = 1'b1;
          state_n    = PULSE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PULSE: begin
        if (cnt == CW'(PULSE_LEN - 1)) begin
          cnt_n      = '0;
          validOut_n = 1'b0;
          if (step < nsteps - 2'd1) begin
            step_n    = step_inc;
            dataOut_n = nxt_val;
            state_n   = SETUP;
          end else begin
            state_n = SETTLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_LEN - 1)) begin
          cnt_n       = '0;
          state_n     = RESP;
          respValid_n = 1'b1;
          respData_n  = ledIn;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        state_n    = IDLE;
        reqReady_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= '0;
      nsteps    <= '0;
      opa       <= '0;
      opb       <= '0;
      op        <= '0;
      reqReady  <= 1'b1;
      dataOut   <= '0;
      validOut  <= 1'b0;
      respValid <= 1'b0;
      respData  <= '0;
      respErr   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      nsteps    <= nsteps_n;
      opa       <= opa_n;
      opb       <= opb_n;
      op        <= op_n;
      reqReady  <= reqReady_n;
      dataOut   <= dataOut_n;
      validOut  <= validOut_n;
      respValid <= respValid_n;
      respData  <= respData_n;
      respErr   <= respErr_n;
    end
  end

endmodule

// File: doc/calc_driver.md
Name: calc_driver

Overview:
- Initiator for the calculator's button/switch interface. It accepts one complete operation per request (operand A, operator, optional operand B) over a ready/valid handshake.
- It serialises the operation onto the calculator's dataIn/validIn inputs as timed, debouncer-compatible pulses.
- After the last pulse it samples the calculator's ledOut and returns the value as the response.
- Used by the board-level self-test and scripted-demo logic in place of a human at the switches.

Parameters:
- PULSE_LEN, 16: cycles validOut is held high per step; must exceed the calculator debouncer's filter length; minimum 1.
- GAP_LEN, 16: cycles validOut is low, with dataOut already driven, before each pulse; minimum 1.
- SETTLE_LEN, 8: cycles after the final pulse before ledIn is sampled; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- reqValid  input  1  request present.
- reqReady  output  1  driver can accept a request.
- reqOpA  input  8  first operand.
- reqOp  input  3  operator code: 0 mul, 1 add, 2 sub, 3 square, 4 inc, 5 dec.
- reqOpB  input  8  second operand; used only for ops 0–2.
- dataOut  output  8  to calculator dataIn.
- validOut  output  1  to calculator validIn (pre-debounce pulse).
- ledIn  input  8  from calculator ledOut.
- respValid  output  1  one-cycle response strobe.
- respData  output  8  sampled result.
- respErr  output  1  qualifies respValid; 1 = unsupported operator, no pulses sent.

Behaviour:
- All outputs registered.
- Reset values: reqReady=1, dataOut=0, validOut=0, respValid=0, respData=0, respErr=0; state=IDLE; step and cycle counters 0.
- States: IDLE, SETUP, PULSE, SETTLE, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid&&reqReady, capture A, op and B; reqReady drops the next cycle.
  - If op>5: go to RESP with respErr=1.
  - Otherwise set nSteps=3 (ops 0–2) or 2 (ops 3–5), step=0, and go to SETUP.
- Step values: step0 = A, step1 = {5'b0,op}, step2 = B.
- SETUP:
  - dataOut = step value, validOut=0, for GAP_LEN cycles, then go to PULSE.
  - The operator is therefore stable on dataIn for at least GAP_LEN cycles before its pulse. The calculator latches the operator one cycle before acting on valid.
- PULSE:
  - validOut=1 for exactly PULSE_LEN cycles; dataOut unchanged.
  - Then, if step<nSteps-1: step++ and go to SETUP. Otherwise go to SETTLE.
- SETTLE:
  - validOut=0; dataOut holds the last step value.
  - After SETTLE_LEN cycles go to RESP.
- RESP:
  - Single cycle: respValid=1; respData=ledIn registered on entry (0 when respErr); respErr as determined in IDLE.
  - Next state IDLE; reqReady=1 from the following cycle.
  - No request is accepted during RESP.
- Latency, counted from the first SETUP cycle (the cycle after acceptance) to the RESP cycle: nSteps*(GAP_LEN+PULSE_LEN)+SETTLE_LEN. Error path: RESP is the cycle after acceptance.
- Arithmetic: the driver does not compute results. respData is the calculator's 8-bit result, i.e. modulo 256 (mul/square truncated, sub and dec wrap).
- validOut is never high in two consecutive steps without at least GAP_LEN low cycles between them.
- reqOp/reqOpA/reqOpB changes after acceptance have no effect.
- Reset mid-operation (any state): on the reset edge, outputs return to reset values, validOut=0, state=IDLE.
  - The calculator must be reset in the same cycle. The driver does not resynchronise a calculator left mid-sequence.
- reqValid held high continuously: exactly one acceptance per IDLE visit; back-to-back requests are spaced by the full latency plus 1 cycle.

Test Plan:
1. Binary add: reqOp=1, A=5, B=7, behavioural calc model attached → dataOut sequence 5,1,7; exactly 3 validOut pulses, each PULSE_LEN long; respValid at 3*(G+P)+S; respData=12, respErr=0.
2. Unary square: reqOp=3, A=12 → 2 pulses (dataOut 12 then 3); respData=144 at 2*(G+P)+S.
3. Wrap: reqOp=2, A=3, B=5 → respData=254. Then reqOp=0, A=20, B=20 → respData=144 (400 mod 256).
4. Illegal op: reqOp=6 → no validOut activity; respValid with respErr=1, respData=0 the cycle after acceptance; reqReady=1 the next cycle.
5. Reset mid-PULSE of step 1: rst=0 for one edge → validOut=0, dataOut=0, reqReady=1 after that edge; a new add request 2+2 then completes with respData=4.
6. Back-to-back: reqValid held high with two queued requests (inc A=255, dec A=0) → second accepted only after the first respValid; results 0 then 255; reqReady=0 throughout each operation.
